// File: rtl/tile_map_sequencer.sv
// Tile-map walker: reads one map entry per 8x8 cell, issues a draw request to the
// tile drawer for each non-empty cell, and waits for the drawer before moving on.
module tile_map_sequencer #(
    parameter int       MAP_COLS   = 20,
    parameter int       MAP_ROWS   = 15,
    parameter int       MAP_AW     = 9,
    parameter bit       SKIP_EN    = 1'b1,
    parameter bit [7:0] SKIP_INDEX = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic [MAP_AW-1:0] o_map_addr,
    input  logic [7:0]        i_map_data,
    output logic [7:0]        o_tile_address,
    output logic [7:0]        o_x_pos,
    output logic [7:0]        o_y_pos,
    output logic              o_draw,
    input  logic              i_drawer_active,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [MAP_AW-1:0] o_tiles_drawn
);
    localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
    localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_MAP, S_CAPTURE, S_ISSUE,
        S_GRACE, S_WAIT_DONE, S_ADVANCE, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [MAP_AW-1:0] r_map_addr;
    logic [MAP_AW-1:0] r_tiles;
    logic [7:0]        r_tile_address;
    logic [7:0]        r_x_pos;
    logic [7:0]        r_y_pos;
    logic              r_draw;
    logic              r_busy;
    logic              r_frame_done;
    logic              w_skip;
    logic              w_last_col;
    logic              w_last_row;

    assign w_skip     = SKIP_EN && (i_map_data == SKIP_INDEX);
    assign w_last_col = (r_col == COL_W'(MAP_COLS - 1));
    assign w_last_row = (r_row == ROW_W'(MAP_ROWS - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_next = S_FETCH;
            S_FETCH:     w_next = S_WAIT_MAP;
            S_WAIT_MAP:  w_next = S_CAPTURE;
            S_CAPTURE:   w_next = w_skip ? S_ADVANCE : S_ISSUE;
            S_ISSUE:     w_next = S_GRACE;
            S_GRACE:     w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!i_drawer_active) w_next = S_ADVANCE;
            S_ADVANCE:   w_next = (w_last_col && w_last_row) ? S_DONE : S_FETCH;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Pulses are decoded from the next state so they are registered yet
    // coincide with the ISSUE / DONE cycles themselves.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col          <= '0;
            r_row          <= '0;
            r_map_addr     <= '0;
            r_tiles        <= '0;
            r_tile_address <= '0;
            r_x_pos        <= '0;
            r_y_pos        <= '0;
            r_draw         <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_draw       <= (w_next == S_ISSUE);
            r_frame_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_col      <= '0;
                        r_row      <= '0;
                        r_map_addr <= '0;
                        r_tiles    <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (!w_skip) begin
                        r_tile_address <= i_map_data;
                        r_x_pos        <= 8'({r_col, 3'b000});
                        r_y_pos        <= 8'({r_row, 3'b000});
                        r_tiles        <= r_tiles + MAP_AW'(1);
                    end
                end
                S_ADVANCE: begin
                    if (w_last_col && w_last_row) begin
                        r_busy <= 1'b0;
                    end else begin
                        // Row-major map layout lets the address simply increment.
                        r_map_addr <= r_map_addr + MAP_AW'(1);
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_map_addr     = r_map_addr;
    assign o_tile_address = r_tile_address;
    assign o_x_pos        = r_x_pos;
    assign o_y_pos        = r_y_pos;
    assign o_draw         = r_draw;
    assign o_busy         = r_busy;
    assign o_frame_done   = r_frame_done;
    assign o_tiles_drawn  = r_tiles;
endmodule

// File: tb/tb_tile_map_sequencer.sv
// Scoreboard bench for tile_map_sequencer: directed maps, a behavioural map RAM
// and drawer, expected draws/frame results queued by stimulus and checked by a monitor.
module tb_tile_map_sequencer;
    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int AW   = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] map_addr;
    logic [7:0]    map_data;
    logic [7:0]    tile_address;
    logic [7:0]    x_pos;
    logic [7:0]    y_pos;
    logic          draw;
    logic          drawer_active;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] tiles_drawn;

    always #5 clk = ~clk;

    tile_map_sequencer #(
        .MAP_COLS(COLS), .MAP_ROWS(ROWS), .MAP_AW(AW),
        .SKIP_EN(1'b1), .SKIP_INDEX(8'hFF)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .o_map_addr(map_addr), .i_map_data(map_data),
        .o_tile_address(tile_address), .o_x_pos(x_pos), .o_y_pos(y_pos),
        .o_draw(draw), .i_drawer_active(drawer_active),
        .o_busy(busy), .o_frame_done(frame_done), .o_tiles_drawn(tiles_drawn)
    );

    // Synchronous map RAM, one cycle read latency
    logic [7:0] mem [0:511];
    always_ff @(posedge clk) map_data <= mem[map_addr];

    // Drawer: active normally, drops low for one cycle dly cycles after a draw
    int dly = 10;
    int drw_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            drw_cnt <= 0;
            drawer_active <= 1'b1;
        end else if (draw) begin
            drw_cnt <= dly;
            drawer_active <= 1'b1;
        end else if (drw_cnt == 1) begin
            drw_cnt <= 0;
            drawer_active <= 1'b0;
        end else begin
            drawer_active <= 1'b1;
            if (drw_cnt > 1) drw_cnt <= drw_cnt - 1;
        end
    end

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] tile;
        logic [7:0] x;
        logic [7:0] y;
    } exp_t;
    exp_t q_draw[$];
    int   q_done[$];

    int n_chk = 0, n_fail = 0, n_draws = 0, n_done = 0, done_cyc = 0, s_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            if (draw) begin
                n_draws++;
                if (q_draw.size() == 0) flag("draw_unexpected");
                else begin
                    e = q_draw.pop_front();
                    chk("draw_x", x_pos, e.x);
                    chk("draw_y", y_pos, e.y);
                    chk("draw_tile", tile_address, e.tile);
                end
            end
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_busy", busy, 0);
                if (q_done.size() == 0) flag("frame_done_unexpected");
                else chk("done_tiles_drawn", tiles_drawn, q_done.pop_front());
            end
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    task automatic push_frame();
        int cnt = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r*COLS+c] != 8'hFF) begin
                    q_draw.push_back({mem[r*COLS+c], 8'(c*8), 8'(r*8)});
                    cnt++;
                end
        q_done.push_back(cnt);
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("addr_after_start", map_addr, 0);
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_done != d0) break;
        end
        if (i == budget) flag("frame_done_timeout");
    endtask

    task automatic wait_draws(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_draws >= target) break;
        end
        if (i == budget) flag("draw_timeout");
    endtask

    task automatic check_drained(input string tag);
        repeat (5) @(negedge clk);
        #1;
        chk({tag, "_draw_q_empty"}, q_draw.size(), 0);
        chk({tag, "_done_q_empty"}, q_done.size(), 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_map_addr"}, map_addr, 0);
        chk({tag, "_tile"}, tile_address, 0);
        chk({tag, "_x"}, x_pos, 0);
        chk({tag, "_y"}, y_pos, 0);
        chk({tag, "_draw"}, draw, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_tiles"}, tiles_drawn, 0);
    endtask

    initial begin
        int base, d0, hold;
        reset = 1'b1;
        start = 1'b0;
        fill(8'h05);
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;

        // 1: full frame, every cell drawn
        base = n_draws;
        push_frame();
        start_frame();
        wait_done(8000);
        check_drained("full");
        chk("full_draw_count", n_draws - base, 300);

        // 2: one empty cell at (3,0)
        fill(8'h10);
        mem[3] = 8'hFF;
        base = n_draws;
        push_frame();
        start_frame();
        wait_done(8000);
        check_drained("skip1");
        chk("skip1_draw_count", n_draws - base, 299);

        // 3: entire map empty; only fetch/skip cost
        fill(8'hFF);
        base = n_draws;
        push_frame();
        start_frame();
        wait_done(2000);
        check_drained("empty");
        chk("empty_draw_count", n_draws - base, 0);
        chk("empty_frame_cycles_in_range",
            (done_cyc - s_cyc >= 1201) && (done_cyc - s_cyc <= 1203), 1);

        // 4: start pulses mid-frame and during DONE are ignored
        fill(8'h05);
        base = n_draws;
        d0 = n_done;
        push_frame();
        start_frame();
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) break;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        chk("restart_done_count", n_done - d0, 1);
        chk("restart_draw_count", n_draws - base, 300);
        check_drained("restart");

        // 5: reset while waiting on the drawer at cell 7
        base = n_draws;
        for (int c = 0; c < 8; c++) q_draw.push_back({8'h05, 8'(c*8), 8'h00});
        start_frame();
        wait_draws(base + 8, 300);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("midrst_no_draw", n_draws - base, 8);
        chk("midrst_q_empty", q_draw.size(), 0);
        push_frame();
        start_frame();
        wait_done(8000);
        check_drained("after_rst");

        // 6: drawer held busy for 500 cycles
        dly = 500;
        base = n_draws;
        q_draw.push_back({8'h05, 8'd0, 8'd0});
        q_draw.push_back({8'h05, 8'd8, 8'd0});
        start_frame();
        wait_draws(base + 1, 50);
        hold = 0;
        while (drawer_active !== 1'b0 && hold < 700) begin
            @(negedge clk);
            #1;
            hold++;
        end
        chk("hold_long_enough", hold >= 499, 1);
        chk("hold_no_new_draw", n_draws - base, 1);
        chk("hold_addr", map_addr, 0);
        @(negedge clk);
        #1;
        chk("release_advance_addr", map_addr, 0);
        @(negedge clk);
        #1;
        chk("release_next_addr", map_addr, 1);
        wait_draws(base + 2, 20);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk("hold_q_empty", q_draw.size(), 0);
        q_done.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
